// File: rtl/branch_resolve_queue.sv
`default_nettype none
// ============================================================================
//  Module   : branch_resolve_queue
//  Purpose  : In-order prediction queue checked at branch resolution; drives
//             predictor update, fetch redirect and branch statistics.
//  Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_queue #(
    parameter  int DEPTH        = 8,
    parameter  int TARGET_WIDTH = 32,
    localparam int PTR_WIDTH    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fetchValid,
    input  logic [31:0]             fetchPc,
    input  logic                    fetchPredTaken,
    input  logic [TARGET_WIDTH-1:0] fetchPredTarget,
    output logic                    fetchReady,
    input  logic                    resValid,
    input  logic                    resBranch,
    input  logic                    resTaken,
    input  logic [TARGET_WIDTH-1:0] resTarget,
    input  logic                    flush,
    output logic                    updValid,
    output logic                    updTaken,
    output logic [31:0]             updPc,
    output logic [TARGET_WIDTH-1:0] updTarget,
    output logic                    redirectValid,
    output logic [31:0]             redirectPc,
    output logic [PTR_WIDTH:0]      occupancy,
    output logic [31:0]             branchCount,
    output logic [31:0]             mispredCount,
    output logic                    protoErr
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    state_t r_state, w_next_state;

    logic [31:0]             r_pc      [DEPTH];
    logic                    r_pred_tk [DEPTH];
    logic [TARGET_WIDTH-1:0] r_pred_tg [DEPTH];

    logic [PTR_WIDTH:0] r_head, r_tail;
    logic [PTR_WIDTH:0] w_head_inc;
    logic               w_empty, w_full;
    logic               w_push, w_pop, w_mispred;
    logic               w_can_fetch;
    logic [31:0]             w_head_pc;
    logic                    w_head_tk;
    logic [TARGET_WIDTH-1:0] w_head_tg;

    assign w_empty    = (r_head == r_tail);
    assign w_full     = (r_head[PTR_WIDTH] != r_tail[PTR_WIDTH]) &&
                        (r_head[PTR_WIDTH-1:0] == r_tail[PTR_WIDTH-1:0]);
    assign w_head_inc = r_head + 1'b1;
    assign occupancy  = r_tail - r_head;

    assign w_head_pc = r_pc[r_head[PTR_WIDTH-1:0]];
    assign w_head_tk = r_pred_tk[r_head[PTR_WIDTH-1:0]];
    assign w_head_tg = r_pred_tg[r_head[PTR_WIDTH-1:0]];

    assign w_pop     = resValid && !w_empty;
    assign w_mispred = w_pop && ((w_head_tk != resTaken) ||
                                 (resTaken && (w_head_tg != resTarget)));

    // Ready is held low while in reset so every output reads 0 there.
    assign fetchReady = rst && w_can_fetch;
    assign w_push     = fetchValid && fetchReady && !flush && !w_mispred;

    always_ff @(posedge clk) begin
        if (!rst) r_state <= RUN;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_can_fetch  = 1'b0;
        case (r_state)
            RUN: begin
                w_can_fetch = !w_full;
                if (w_mispred || flush) w_next_state = REDIRECT;
            end
            REDIRECT: begin
                w_next_state = (w_mispred || flush) ? REDIRECT : RUN;
            end
            default: w_next_state = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc[r_tail[PTR_WIDTH-1:0]]      <= fetchPc;
            r_pred_tk[r_tail[PTR_WIDTH-1:0]] <= fetchPredTaken;
            r_pred_tg[r_tail[PTR_WIDTH-1:0]] <= fetchPredTarget;
        end
    end

    // Squash of any kind collapses the queue to just past the popped head.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (flush || w_mispred) begin
            r_head <= w_pop ? w_head_inc : r_head;
            r_tail <= w_pop ? w_head_inc : r_head;
        end else begin
            if (w_pop)  r_head <= w_head_inc;
            if (w_push) r_tail <= r_tail + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            updValid      <= 1'b0;
            updTaken      <= 1'b0;
            updPc         <= '0;
            updTarget     <= '0;
            redirectValid <= 1'b0;
            redirectPc    <= '0;
            branchCount   <= '0;
            mispredCount  <= '0;
            protoErr      <= 1'b0;
        end else begin
            updValid      <= w_pop && (resBranch || w_head_tk);
            redirectValid <= w_mispred;
            if (w_pop) begin
                updTaken   <= resTaken;
                updPc      <= w_head_pc;
                updTarget  <= resTarget;
                redirectPc <= resTaken ? 32'(resTarget) : (w_head_pc + 32'd4);
                if (resBranch && (branchCount != 32'hFFFF_FFFF))
                    branchCount <= branchCount + 32'd1;
                if (w_mispred && (mispredCount != 32'hFFFF_FFFF))
                    mispredCount <= mispredCount + 32'd1;
            end
            if (resValid && w_empty) protoErr <= 1'b1;
        end
    end

endmodule
`default_nettype wire
